// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce input stage: state encoding and default sizing.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b11,
    PEND_LO   = 2'b10
  } db_state_e;

  localparam int unsigned DEF_STABLE_CYCLES = 4;
  localparam int unsigned DEF_CNT_W         = 3;

endpackage

// File: rtl/sync_2ff.sv
// Two-register synchronizer for a single asynchronous bit; both stages clear on reset.
module sync_2ff (
  input  logic Clk,
  input  logic Rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes a bouncing input and accepts a new level only after it holds for
// STABLE_CYCLES consecutive synchronized cycles; emits one-cycle edge pulses.
//
// state     | meaning
// STABLE_LO | accepted level is 0, synchronized input agrees
// PEND_HI   | input reads 1, counting consecutive 1 cycles
// STABLE_HI | accepted level is 1, synchronized input agrees
// PEND_LO   | input reads 0, counting consecutive 0 cycles
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic Clk,
  input  logic Rst,
  input  logic D_raw,
  output logic D_clean,
  output logic Rise,
  output logic Fall,
  output logic Busy
);

  if ((STABLE_CYCLES < 2) || (STABLE_CYCLES > ((1 << CNT_W) - 1))) begin : g_bad_params
    $error("debounce_sync: STABLE_CYCLES must lie in 2..2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_lvl;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clean_q;
  logic             rise_q;
  logic             fall_q;

  sync_2ff u_sync (
    .Clk      (Clk),
    .Rst      (Rst),
    .async_in (D_raw),
    .sync_out (sync_lvl)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE_LO: begin
          if (sync_lvl) begin
            state_q <= PEND_HI;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        PEND_HI: begin
          if (!sync_lvl) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_HI;
            clean_q <= 1'b1;
            rise_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!sync_lvl) begin
            state_q <= PEND_LO;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        PEND_LO: begin
          if (sync_lvl) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_LO;
            clean_q <= 1'b0;
            fall_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= STABLE_LO;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign D_clean = clean_q;
  assign Rise    = rise_q;
  assign Fall    = fall_q;
  assign Busy    = (state_q == PEND_HI) || (state_q == PEND_LO);

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: a history-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_debounce_sync;

  localparam int S = 4;

  logic Clk = 1'b0;
  logic Rst;
  logic D_raw;
  logic D_clean, Rise, Fall, Busy;

  debounce_sync #(.STABLE_CYCLES(S), .CNT_W(3)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .D_raw   (D_raw),
    .D_clean (D_clean),
    .Rise    (Rise),
    .Fall    (Fall),
    .Busy    (Busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passes = 0;
  int edge_cnt = 0;
  int rise_count = 0;
  int fall_count = 0;
  int last_rise_edge = -1;
  int last_fall_edge = -1;

  // Reference model: the accepted level flips once the last S synchronized
  // samples all disagree with it; pending means the newest sample disagrees.
  bit model_valid = 1'b0;
  bit ms1, ms2;
  bit hist[$];
  bit m_clean, m_rise, m_fall, m_busy;
  bit all_new;

  always @(posedge Clk) begin
    edge_cnt++;
    if (Rst) begin
      ms1 = 1'b0; ms2 = 1'b0;
      hist.delete();
      m_clean = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0;
    end else begin
      hist.push_back(ms2);
      if (hist.size() > S) void'(hist.pop_front());
      all_new = (hist.size() == S);
      foreach (hist[i]) if (hist[i] == m_clean) all_new = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (all_new) begin
        m_clean = !m_clean;
        m_rise  = m_clean;
        m_fall  = !m_clean;
        hist.delete();
      end
      m_busy = (hist.size() > 0) && (hist[hist.size()-1] != m_clean);
      ms2 = ms1;
      ms1 = D_raw;
    end
    model_valid = 1'b1;
    #1;
    if (Rise) begin rise_count++; last_rise_edge = edge_cnt; end
    if (Fall) begin fall_count++; last_fall_edge = edge_cnt; end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, got, exp);
  endtask

  always @(negedge Clk) begin
    if (model_valid) begin
      check("model_clean", D_clean, m_clean);
      check("model_rise",  Rise,    m_rise);
      check("model_fall",  Fall,    m_fall);
      check("model_busy",  Busy,    m_busy);
      if (Rise && Fall) check("rise_fall_together", 1, 0);
    end
  end

  // Apply a held level change and check the 5-edge acceptance profile literally.
  task automatic step_change(input bit v, input string tag);
    int r0, f0;
    r0 = rise_count;
    f0 = fall_count;
    D_raw = v;
    for (int k = 0; k <= 6; k++) begin
      @(negedge Clk);
      check({tag, "_busy"},  Busy,    (k >= 2 && k <= 4) ? 1 : 0);
      check({tag, "_clean"}, D_clean, (k >= 5) ? int'(v) : int'(!v));
      check({tag, "_rise"},  Rise,    (k == 5 && v) ? 1 : 0);
      check({tag, "_fall"},  Fall,    (k == 5 && !v) ? 1 : 0);
    end
    check({tag, "_rise_cnt"}, rise_count - r0, v ? 1 : 0);
    check({tag, "_fall_cnt"}, fall_count - f0, v ? 0 : 1);
  endtask

  initial begin
    int n, m, r0, f0;
    bit bounce [5];
    bounce = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    Rst = 1'b1;
    D_raw = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      check("reset_clean", D_clean, 0);
      check("reset_rise",  Rise, 0);
      check("reset_fall",  Fall, 0);
      check("reset_busy",  Busy, 0);
    end

    // D_raw already high when reset releases: a normal 0->1 acceptance.
    Rst = 1'b0;
    n = edge_cnt + 1;
    step_change(1'b1, "rst_release");
    check("rst_release_rise_edge", last_rise_edge, n + 5);

    step_change(1'b0, "release1");
    n = edge_cnt + 1;
    step_change(1'b1, "press");
    check("press_rise_edge", last_rise_edge, n + 5);
    n = edge_cnt + 1;
    step_change(1'b0, "release2");
    check("release2_fall_edge", last_fall_edge, n + 5);

    // Two-cycle glitch while low: pending for two cycles, then back to idle.
    r0 = rise_count;
    D_raw = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge Clk);
      if (k == 1) D_raw = 1'b0;
      check("glitch_busy",  Busy, (k == 2 || k == 3) ? 1 : 0);
      check("glitch_clean", D_clean, 0);
    end
    check("glitch_no_rise", rise_count - r0, 0);

    // Bouncy press: one Rise, S+1 edges after the final 0->1.
    r0 = rise_count;
    m = 0;
    foreach (bounce[i]) begin
      D_raw = bounce[i];
      if (i == 4) m = edge_cnt + 1;
      @(negedge Clk);
    end
    repeat (12) @(negedge Clk);
    check("bounce_rise_cnt",  rise_count - r0, 1);
    check("bounce_rise_edge", last_rise_edge, m + S + 1);
    check("bounce_clean",     D_clean, 1);

    f0 = fall_count;
    r0 = rise_count;
    step_change(1'b0, "release3");
    check("release3_no_rise", rise_count - r0, 0);
    check("release3_fall_cnt", fall_count - f0, 1);

    // Reset while a press is pending aborts it without any pulse.
    r0 = rise_count;
    D_raw = 1'b1;
    repeat (3) @(negedge Clk);
    check("midrst_busy_before", Busy, 1);
    Rst = 1'b1;
    @(negedge Clk);
    check("midrst_busy",  Busy, 0);
    check("midrst_clean", D_clean, 0);
    check("midrst_rise",  Rise, 0);
    D_raw = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    repeat (10) @(negedge Clk);
    check("midrst_no_rise", rise_count - r0, 0);
    check("midrst_clean_after", D_clean, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
